// File: rtl/frame_write_pkg.sv
// Shared types for the frame writer: FSM state encoding and byte-address width.
package frame_write_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_REQ,
    S_XFER,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/frame_write_fifo.sv
// Staging FIFO between the pixel stream and the DDR write master.
// Circular buffer with exact count; head word is visible combinationally.
module frame_write_fifo
  import frame_write_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/frame_write_fsm.sv
// Frame writer: stages pixels and issues DDR write bursts line by line.
// Optional FRAME_WRITE_STATS_EN adds burst and stall counters.
module frame_write_fsm
  import frame_write_pkg::*;
#(
  parameter int C_DWIDTH     = 32,
  parameter int C_BURST_LEN  = 16,
  parameter int C_FIFO_DEPTH = 32
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Resetn,
  input  logic                start_frame,
  input  logic [ADDR_W-1:0]   FRAME_BASE_ADDR,
  input  logic [ADDR_W-1:0]   LINE_STRIDE,
  input  logic [ADDR_W-1:0]   NUM_PIXELS_PER_LINE,
  input  logic [ADDR_W-1:0]   NUM_BYTES_PER_PIXEL,
  input  logic [ADDR_W-1:0]   NUM_LINES,
  input  logic                pix_valid,
  input  logic [C_DWIDTH-1:0] pix_data,
  output logic                pix_ready,
  output logic [ADDR_W-1:0]   ddr_addr_to_write,
  output logic [7:0]          burst_len,
  output logic                go_write_burst,
  input  logic                write_ack,
  output logic [C_DWIDTH-1:0] wr_data,
  input  logic                wr_data_pop,
  input  logic                write_done,
  output logic                frame_done,
  output logic                busy
`ifdef FRAME_WRITE_STATS_EN
  ,
  output logic [31:0]         stat_bursts,
  output logic [31:0]         stat_stalls
`endif
);

  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] g_stride;
  logic [ADDR_W-1:0] g_npix;
  logic [ADDR_W-1:0] g_bpp;
  logic [ADDR_W-1:0] g_lines;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] line;
  logic [ADDR_W-1:0] pix_left;
  logic [ADDR_W-1:0] bl_w;
  logic [ADDR_W-1:0] pix_rem;
  logic [ADDR_W-1:0] line_nx;

  logic [CW-1:0]       fifo_count;
  logic [C_DWIDTH-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                start_ok;
  logic                geom_zero;
  logic                line_end;

  assign busy      = state != S_IDLE;
  assign start_ok  = start_frame && state == S_IDLE;
  assign geom_zero = NUM_LINES == '0 || NUM_PIXELS_PER_LINE == '0;

  assign bl_w      = (pix_left < ADDR_W'(C_BURST_LEN)) ?
                     pix_left : ADDR_W'(C_BURST_LEN);
  assign burst_len = bl_w[7:0];
  assign pix_rem   = pix_left - bl_w;
  assign line_nx   = line + ADDR_W'(1);
  assign line_end  = pix_rem == '0;

  assign pix_ready         = busy && !fifo_full;
  assign push              = pix_valid && pix_ready;
  assign go_write_burst    = state == S_REQ;
  assign frame_done        = state == S_DONE;
  assign ddr_addr_to_write = addr;
  // Mask stale RAM contents so an empty FIFO always presents zero
  assign wr_data           = fifo_empty ? '0 : fifo_head;

  frame_write_fifo #(
    .DW    (C_DWIDTH),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk       (Bus2IP_Clk),
    .rst_n     (Bus2IP_Resetn),
    .push      (push),
    .push_data (pix_data),
    .pop       (wr_data_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) state <= S_IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (start_frame)
          state_nx = geom_zero ? S_DONE : S_WAIT_DATA;
      S_WAIT_DATA:
        if (ADDR_W'(fifo_count) >= bl_w) state_nx = S_REQ;
      S_REQ:
        if (write_ack) state_nx = S_XFER;
      S_XFER:
        if (write_done) state_nx = S_NEXT;
      S_NEXT:
        state_nx = (line_end && line_nx == g_lines) ?
                   S_DONE : S_WAIT_DATA;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      g_stride  <= '0;
      g_npix    <= '0;
      g_bpp     <= '0;
      g_lines   <= '0;
      line_base <= '0;
      addr      <= '0;
      line      <= '0;
      pix_left  <= '0;
    end else if (start_ok) begin
      g_stride  <= LINE_STRIDE;
      g_npix    <= NUM_PIXELS_PER_LINE;
      g_bpp     <= NUM_BYTES_PER_PIXEL;
      g_lines   <= NUM_LINES;
      line_base <= FRAME_BASE_ADDR;
      addr      <= FRAME_BASE_ADDR;
      line      <= '0;
      pix_left  <= NUM_PIXELS_PER_LINE;
    end else if (state == S_NEXT) begin
      if (line_end) begin
        line      <= line_nx;
        line_base <= line_base + g_stride;
        addr      <= line_base + g_stride;
        pix_left  <= g_npix;
      end else begin
        pix_left  <= pix_rem;
        addr      <= addr + bl_w * g_bpp;
      end
    end
  end

`ifdef FRAME_WRITE_STATS_EN
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      stat_bursts <= '0;
      stat_stalls <= '0;
    end else if (start_ok) begin
      stat_bursts <= '0;
      stat_stalls <= '0;
    end else begin
      if (write_done)              stat_bursts <= stat_bursts + 1'b1;
      if (pix_valid && !pix_ready) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_write_fsm.sv
// Testbench for frame_write_fsm: random pixel source and DDR master
// against a burst-list / data-order reference model.
module tb_frame_write_fsm;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_frame;
  logic [31:0]   g_base, g_stride, g_npix, g_bpp, g_lines;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic [31:0]   ddr_addr_to_write;
  logic [7:0]    burst_len;
  logic          go_write_burst;
  logic          write_ack;
  logic [DW-1:0] wr_data;
  logic          wr_data_pop;
  logic          write_done;
  logic          frame_done;
  logic          busy;
`ifdef FRAME_WRITE_STATS_EN
  logic [31:0]   stat_bursts;
  logic [31:0]   stat_stalls;
`endif

  always #5 clk = ~clk;

  frame_write_fsm #(
    .C_DWIDTH(DW), .C_BURST_LEN(16), .C_FIFO_DEPTH(32)
  ) dut (
    .Bus2IP_Clk          (clk),
    .Bus2IP_Resetn       (rst_n),
    .start_frame         (start_frame),
    .FRAME_BASE_ADDR     (g_base),
    .LINE_STRIDE         (g_stride),
    .NUM_PIXELS_PER_LINE (g_npix),
    .NUM_BYTES_PER_PIXEL (g_bpp),
    .NUM_LINES           (g_lines),
    .pix_valid           (pix_valid),
    .pix_data            (pix_data),
    .pix_ready           (pix_ready),
    .ddr_addr_to_write   (ddr_addr_to_write),
    .burst_len           (burst_len),
    .go_write_burst      (go_write_burst),
    .write_ack           (write_ack),
    .wr_data             (wr_data),
    .wr_data_pop         (wr_data_pop),
    .write_done          (write_done),
    .frame_done          (frame_done),
    .busy                (busy)
`ifdef FRAME_WRITE_STATS_EN
    ,
    .stat_bursts         (stat_bursts),
    .stat_stalls         (stat_stalls)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  logic [31:0] obs_addr[$];
  int          obs_len[$];
  logic [31:0] exp_addr[$];
  int          exp_len[$];

  bit          src_en, src_cont, m_en, m_hold;
  int          src_total, src_sent;
  logic [31:0] src_val = 32'hA500_0001;
  int          m_st, m_left;
  int          done_cnt, go_cnt;

  // pixel source
  always @(posedge clk) begin
    #1;
    if (src_en) begin
      if (src_sent < src_total) begin
        pix_valid = src_cont || ($urandom_range(0, 3) != 0);
        pix_data  = src_val;
      end else begin
        pix_valid = 1'b0;
      end
    end
  end

  // DDR write master
  always @(posedge clk) begin
    #1;
    write_ack   = 1'b0;
    write_done  = 1'b0;
    wr_data_pop = 1'b0;
    if (m_en) begin
      if (m_st == 0) begin
        if (go_write_burst && $urandom_range(0, 2) != 0) begin
          write_ack = 1'b1;
          obs_addr.push_back(ddr_addr_to_write);
          obs_len.push_back(int'(burst_len));
          m_left = int'(burst_len);
          m_st = 1;
        end
      end else if (!m_hold) begin
        if (m_left > 0) begin
          if ($urandom_range(0, 3) != 0) begin
            wr_data_pop = 1'b1;
            out_q.push_back(wr_data);
            m_left--;
          end
        end else begin
          write_done = 1'b1;
          m_st = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (src_en && pix_valid && pix_ready) begin
      in_q.push_back(pix_data);
      src_sent++;
      src_val++;
    end
    if (frame_done) done_cnt++;
    if (go_write_burst) go_cnt++;
  end

  task automatic build_exp(input logic [31:0] base, stride, npix,
                           bpp, lines);
    logic [31:0] off;
    int bl;
    exp_addr.delete();
    exp_len.delete();
    for (int l = 0; l < int'(lines); l++) begin
      off = 0;
      while (off < npix) begin
        bl = (npix - off > 16) ? 16 : int'(npix - off);
        exp_addr.push_back(base + stride * l + off * bpp);
        exp_len.push_back(bl);
        off += bl;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_en = 0; m_en = 0; m_hold = 0; m_st = 0;
    start_frame = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic start_task(input logic [31:0] base, stride, npix,
                            bpp, lines, input bit s_on, cont,
                            hold, men);
    @(negedge clk); #1;
    g_base = base; g_stride = stride; g_npix = npix;
    g_bpp = bpp; g_lines = lines;
    build_exp(base, stride, npix, bpp, lines);
    in_q.delete(); out_q.delete();
    obs_addr.delete(); obs_len.delete();
    src_total = int'(npix * lines);
    src_sent = 0;
    src_en = s_on; src_cont = cont;
    m_hold = hold; m_en = men;
    done_cnt = 0; go_cnt = 0;
    start_frame = 1'b1;
    @(negedge clk); #1;
    start_frame = 1'b0;
    g_base = $urandom; g_stride = $urandom; g_npix = $urandom;
    g_bpp = $urandom; g_lines = $urandom;
  endtask

  task automatic wait_done(output bit to);
    to = 1;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) begin
        to = 0;
        break;
      end
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, pix_ready, go_write_burst, frame_done} !== 4'b0 ||
        burst_len !== 8'd0 || ddr_addr_to_write !== 32'd0 ||
        wr_data !== '0) begin
      failures++;
      $display("FAIL reset_in got busy=%b rdy=%b go=%b fd=%b bl=%0d a=%h d=%h want all 0",
               busy, pix_ready, go_write_burst, frame_done, burst_len,
               ddr_addr_to_write, wr_data);
    end
    do_reset();
    checks++;
    if ({busy, pix_ready, go_write_burst, frame_done} !== 4'b0 ||
        burst_len !== 8'd0 || ddr_addr_to_write !== 32'd0) begin
      failures++;
      $display("FAIL reset_out got busy=%b rdy=%b go=%b bl=%0d a=%h want 0",
               busy, pix_ready, go_write_burst, burst_len,
               ddr_addr_to_write);
    end
  endtask

  task automatic test_frame(input logic [31:0] base, stride, npix,
                            bpp, lines, input bit cont,
                            input string nm);
    bit to;
    start_task(base, stride, npix, bpp, lines, 1, cont, 0, 1);
    wait_done(to);
    checks++;
    if (to || done_cnt != 1) begin
      failures++;
      $display("FAIL %s frame_done timeout=%0d pulses=%0d want 0/1",
               nm, to, done_cnt);
    end
    checks++;
    if (obs_len.size() != exp_len.size()) begin
      failures++;
      $display("FAIL %s nbursts got %0d want %0d", nm,
               obs_len.size(), exp_len.size());
    end
    for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_len[i] != exp_len[i]) begin
        failures++;
        $display("FAIL %s burst%0d got %h/%0d want %h/%0d", nm, i,
                 obs_addr[i], obs_len[i], exp_addr[i], exp_len[i]);
      end
    end
    checks++;
    if (in_q.size() != src_total || out_q.size() != src_total) begin
      failures++;
      $display("FAIL %s words in=%0d out=%0d want %0d", nm,
               in_q.size(), out_q.size(), src_total);
    end
    for (int i = 0; i < in_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== in_q[i]) begin
        failures++;
        $display("FAIL %s data%0d got %h want %h", nm, i,
                 out_q[i], in_q[i]);
      end
    end
    checks++;
    if (busy !== 1'b0 || wr_data !== '0) begin
      failures++;
      $display("FAIL %s idle got busy=%b head=%h want 0/0", nm,
               busy, wr_data);
    end
  endtask

  task automatic test_short_line();
    logic [31:0] b;
    b = {$urandom_range(0, 255), 24'h0};
    test_frame(b, 32'h1000, 40, 4, 1, 0, "short_line");
    checks++;
    if (obs_len.size() != 3 || obs_len[2] != 8 ||
        obs_addr[2] !== b + 32'h80) begin
      failures++;
      $display("FAIL short_tail got n=%0d want 3 bursts, last 8 @ %h",
               obs_len.size(), b + 32'h80);
    end
  endtask

  task automatic test_random();
    logic [31:0] b;
    for (int it = 0; it < 4; it++) begin
      b = (it == 0) ? 32'hFFFF_FF80 : $urandom;
      test_frame(b, $urandom_range(0, 32'h2000),
                 $urandom_range(1, 45), $urandom_range(1, 4),
                 $urandom_range(1, 3), $urandom_range(0, 1) == 1,
                 "random");
    end
  endtask

  task automatic test_backpressure();
    bit to, seen;
    start_task(32'h4000_0000, 32'h800, 256, 4, 1, 1, 1, 1, 1);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (!pix_ready) seen = 1;
    end
    checks++;
    if (!seen || in_q.size() != 32 || out_q.size() != 0) begin
      failures++;
      $display("FAIL bp_full seen=%0d accepted=%0d popped=%0d want 1/32/0",
               seen, in_q.size(), out_q.size());
    end
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (in_q.size() != 32 || pix_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold accepted=%0d rdy=%b want 32/0",
               in_q.size(), pix_ready);
    end
    m_hold = 0;
    wait_done(to);
    checks++;
    if (to || out_q.size() != 256 || in_q.size() != 256) begin
      failures++;
      $display("FAIL bp_end timeout=%0d in=%0d out=%0d want 0/256/256",
               to, in_q.size(), out_q.size());
    end
    for (int i = 0; i < in_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== in_q[i]) begin
        failures++;
        $display("FAIL bp_data%0d got %h want %h", i, out_q[i], in_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_xfer();
    bit seen;
    start_task(32'h0100_0000, 32'h100, 64, 4, 1, 1, 1, 1, 1);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (m_st == 1) seen = 1;
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    src_en = 0; m_en = 0; m_st = 0; m_hold = 0;
    pix_valid = 1'b0;
    #1;
    checks++;
    if (!seen || busy !== 1'b0 || go_write_burst !== 1'b0 ||
        pix_ready !== 1'b0 || wr_data !== '0 ||
        burst_len !== 8'd0 || ddr_addr_to_write !== 32'd0) begin
      failures++;
      $display("FAIL rst_xfer seen=%0d busy=%b go=%b head=%h bl=%0d a=%h want 1/0/0/0/0/0",
               seen, busy, go_write_burst, wr_data, burst_len,
               ddr_addr_to_write);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || go_write_burst !== 1'b0 || wr_data !== '0) begin
      failures++;
      $display("FAIL rst_next busy=%b go=%b head=%h want 0", busy,
               go_write_burst, wr_data);
    end
    do_reset();
    test_frame(32'h0777_0000, 32'h100, 32, 4, 1, 0, "after_rst");
    checks++;
    if (obs_addr.size() == 0 || obs_addr[0] !== 32'h0777_0000) begin
      failures++;
      $display("FAIL rst_restart first addr got %h want 07770000",
               (obs_addr.size() > 0) ? obs_addr[0] : 32'hx);
    end
  endtask

  task automatic test_start_during_req();
    bit to, seen;
    start_task(32'h2000_0000, 32'h100, 32, 4, 1, 1, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (go_write_burst) seen = 1;
    end
    g_base = 32'h3000_0000; g_npix = 8; g_lines = 1; g_bpp = 2;
    start_frame = 1'b1;
    @(negedge clk); #1;
    start_frame = 1'b0;
    checks++;
    if (!seen || go_write_burst !== 1'b1 ||
        ddr_addr_to_write !== 32'h2000_0000 || burst_len !== 8'd16) begin
      failures++;
      $display("FAIL req_restart seen=%0d go=%b a=%h bl=%0d want 1/1/20000000/16",
               seen, go_write_burst, ddr_addr_to_write, burst_len);
    end
    m_en = 1;
    wait_done(to);
    checks++;
    if (to || done_cnt != 1 || obs_len.size() != exp_len.size()) begin
      failures++;
      $display("FAIL req_end timeout=%0d pulses=%0d n=%0d want 0/1/%0d",
               to, done_cnt, obs_len.size(), exp_len.size());
    end
    for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_len[i] != exp_len[i]) begin
        failures++;
        $display("FAIL req_burst%0d got %h/%0d want %h/%0d", i,
                 obs_addr[i], obs_len[i], exp_addr[i], exp_len[i]);
      end
    end
  endtask

  task automatic test_zero_geom(input logic [31:0] npix, lines);
    int first, pulses;
    bit go_seen;
    @(negedge clk); #1;
    g_base = 32'h5000_0000; g_stride = 32'h100; g_bpp = 4;
    g_npix = npix; g_lines = lines;
    src_en = 0; m_en = 0;
    start_frame = 1'b1;
    first = 0; pulses = 0; go_seen = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      start_frame = 1'b0;
      if (frame_done) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (go_write_burst) go_seen = 1;
    end
    checks++;
    if (first < 1 || first > 2 || pulses != 1 || go_seen ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_geom px=%0d ln=%0d first=%0d pulses=%0d go=%0d busy=%b want 1..2/1/0/0",
               npix, lines, first, pulses, go_seen, busy);
    end
  endtask

`ifdef FRAME_WRITE_STATS_EN
  task automatic test_stats();
    bit to;
    do_reset();
    checks++;
    if (stat_bursts !== 32'd0 || stat_stalls !== 32'd0) begin
      failures++;
      $display("FAIL stat_reset got %0d/%0d want 0/0", stat_bursts,
               stat_stalls);
    end
    start_task(32'h8000_0000, 32'h4000, 256, 4, 2, 1, 0, 0, 1);
    wait_done(to);
    checks++;
    if (to || stat_bursts !== 32'(exp_len.size())) begin
      failures++;
      $display("FAIL stat_bursts got %0d want %0d", stat_bursts,
               exp_len.size());
    end
    do_reset();
    start_task(32'h0, 32'h400, 256, 4, 1, 0, 0, 0, 0);
    for (int i = 0; i < 42; i++) begin
      pix_valid = 1'b1;
      pix_data = i;
      @(negedge clk); #1;
    end
    pix_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (stat_stalls !== 32'd10) begin
      failures++;
      $display("FAIL stat_stalls got %0d want 10", stat_stalls);
    end
    do_reset();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start_frame = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    write_ack = 1'b0;
    write_done = 1'b0;
    wr_data_pop = 1'b0;
    g_base = '0; g_stride = '0; g_npix = '0; g_bpp = '0; g_lines = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_frame(32'h8000_0000, 32'h4000, 256, 4, 2, 0, "frame_2x256");
    test_short_line();
    test_backpressure();
    test_random();
    test_start_during_req();
    test_zero_geom(32'd20, 32'd0);
    test_zero_geom(32'd0, 32'd3);
    test_reset_mid_xfer();
`ifdef FRAME_WRITE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
